// File: rtl/div_seq_if.sv
// Execute-stage <-> sequential divider handshake bundle.
// The pipeline drives the request side; the divider returns result and status.
interface div_seq_if;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [63:0] div_res;
  logic        div_ready;
  logic        div_busy;
  logic        div_dbz;
  logic        stallreq_div;

  modport master (
    output div_start, div_signed, dividend, divisor, annul,
    input  div_res, div_ready, div_busy, div_dbz, stallreq_div
  );

  modport slave (
    input  div_start, div_signed, dividend, divisor, annul,
    output div_res, div_ready, div_busy, div_dbz, stallreq_div
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Operates on magnitudes and applies signs on the final iteration.
module div_seq #(
  parameter int CYCLES = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(CYCLES);

  typedef enum logic [1:0] {FREE, DBZ, ON, END} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   quo;
  logic [31:0]   dvs;
  logic [32:0]   rem;
  logic          q_neg;
  logic          r_neg;

  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, rem_step;
  logic [31:0] quo_step, quo_fix, rem_fix;
  logic        q_bit, last;

  assign a_mag = (bus.div_signed && bus.dividend[31]) ? -bus.dividend : bus.dividend;
  assign b_mag = (bus.div_signed && bus.divisor[31])  ? -bus.divisor  : bus.divisor;

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh   = {rem[31:0], quo[31]};
  assign q_bit    = (rem_sh >= {1'b0, dvs});
  assign rem_step = q_bit ? (rem_sh - {1'b0, dvs}) : rem_sh;
  assign quo_step = {quo[30:0], q_bit};
  assign last     = (cnt == CW'(CYCLES - 1));
  assign quo_fix  = q_neg ? -quo_step : quo_step;
  assign rem_fix  = r_neg ? -rem_step[31:0] : rem_step[31:0];

  assign bus.div_busy     = (state == ON);
  assign bus.stallreq_div = rst_n & bus.div_start & ~bus.div_ready & ~bus.annul;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FREE;
    else        state <= state_nxt;
  end

  // NOTE: next-state defaults to the current state first, so no path leaves
  // state_nxt unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (bus.annul) begin
      state_nxt = FREE;
    end else begin
      case (state)
        FREE: if (bus.div_start) state_nxt = (bus.divisor == 32'd0) ? DBZ : ON;
        DBZ:  state_nxt = END;
        ON:   if (last) state_nxt = END;
        END:  if (!bus.div_start) state_nxt = FREE;
        default: state_nxt = FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      quo           <= '0;
      dvs           <= '0;
      rem           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      bus.div_res   <= '0;
      bus.div_ready <= 1'b0;
      bus.div_dbz   <= 1'b0;
    end else if (bus.annul) begin
      // Flush drops any partial or held result so it is never presented.
      bus.div_res   <= '0;
      bus.div_ready <= 1'b0;
      bus.div_dbz   <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (bus.div_start && bus.divisor != 32'd0) begin
            cnt   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            rem   <= '0;
            q_neg <= bus.div_signed & (bus.dividend[31] ^ bus.divisor[31]);
            r_neg <= bus.div_signed & bus.dividend[31];
          end
        end
        DBZ: begin
          bus.div_res <= '0;
          bus.div_dbz <= 1'b1;
        end
        ON: begin
          quo <= quo_step;
          rem <= rem_step;
          cnt <= cnt + 1'b1;
          if (last) bus.div_res <= {rem_fix, quo_fix};
        end
        END: begin
          if (bus.div_start) begin
            bus.div_ready <= 1'b1;
          end else begin
            bus.div_ready <= 1'b0;
            bus.div_dbz   <= 1'b0;
            bus.div_res   <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  div_seq_if bus ();

  div_seq #(.CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {dbz, remainder, quotient} from plain integer arithmetic.
  function automatic logic [64:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {1'b1, 64'd0};
    if (sg) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, r[31:0], q[31:0]};
  endfunction

  task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        input bit change_ops, input string tag);
    logic [64:0] exp;
    int lat, lat_exp;
    exp     = model(sg, a, b);
    lat_exp = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    bus.div_signed = sg;
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_start  = 1'b1;
    #1 check({tag, "_stall_req"}, 64'(bus.stallreq_div), 64'd1);
    @(posedge clk); #1;
    check({tag, "_busy_accept"}, 64'(bus.div_busy), 64'(b != 32'd0));
    lat = 0;
    while (!bus.div_ready && lat < 40) begin
      if (change_ops && lat == 10) begin
        bus.dividend   = $urandom;
        bus.divisor    = $urandom;
        bus.div_signed = ~sg;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_res"}, bus.div_res, exp[63:0]);
    check({tag, "_dbz"}, 64'(bus.div_dbz), 64'(exp[64]));
    check({tag, "_stall_done"}, 64'(bus.stallreq_div), 64'd0);
    @(posedge clk); #1;
    check({tag, "_res_hold"}, {bus.div_ready, bus.div_res}, {1'b1, exp[63:0]});
    @(negedge clk);
    bus.div_start = 1'b0;
    @(posedge clk); #1;
    check({tag, "_release"}, {bus.div_ready, bus.div_dbz, bus.div_busy, bus.div_res},
          {3'b000, 64'd0});
  endtask

  initial begin
    int seen_ready;
    rst_n          = 1'b0;
    bus.div_start  = 1'b1;
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd100;
    bus.divisor    = 32'd7;
    bus.annul      = 1'b0;
    #1 check("stall_in_reset", 64'(bus.stallreq_div), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.div_ready, bus.div_dbz, bus.div_busy, bus.div_res},
          {3'b000, 64'd0});
    bus.div_start = 1'b0;
    rst_n = 1'b1;

    // Directed corner cases.
    run_op(1'b0, 32'd100,        32'd7,          1'b0, "divu_100_7");
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,          1'b0, "div_m7_2");
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE,  1'b0, "div_7_m2");
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, "div_min_m1");
    run_op(1'b0, 32'hFFFF_FFFF,  32'd1,          1'b0, "divu_max_1");
    run_op(1'b0, 32'd5,          32'd0,          1'b0, "divu_dbz");
    run_op(1'b1, 32'h8000_0000,  32'h8000_0000,  1'b0, "div_min_min");
    run_op(1'b0, 32'h8000_0000,  32'd3,          1'b1, "divu_opchange");

    // Start together with annul in FREE is ignored.
    @(negedge clk);
    bus.div_start = 1'b1;
    bus.annul     = 1'b1;
    bus.divisor   = 32'd3;
    #1 check("annul_start_stall", 64'(bus.stallreq_div), 64'd0);
    @(posedge clk); #1;
    check("annul_start_busy", 64'(bus.div_busy), 64'd0);
    @(negedge clk);
    bus.div_start = 1'b0;
    bus.annul     = 1'b0;

    // Annul during the 10th ON cycle.
    @(negedge clk);
    bus.div_signed = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd9;
    bus.div_start  = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1;
    check("annul_busy_before", 64'(bus.div_busy), 64'd1);
    bus.annul = 1'b1;
    @(posedge clk); #1;
    check("annul_flush", {bus.div_busy, bus.div_ready, bus.div_dbz}, 64'd0);
    bus.annul     = 1'b0;
    bus.div_start = 1'b0;
    seen_ready = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.div_ready || bus.div_busy) seen_ready++;
    end
    check("annul_no_result", 64'(seen_ready), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, 1'b0, "after_annul_9_3");

    // Reset during ON cycle 20; the first start afterwards goes straight in.
    @(negedge clk);
    bus.div_signed = 1'b1;
    bus.dividend   = 32'hDEAD_BEEF;
    bus.divisor    = 32'd77;
    bus.div_start  = 1'b1;
    @(posedge clk);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1 check("stall_rst_mid", 64'(bus.stallreq_div), 64'd0);
    @(posedge clk); #1;
    check("rst_mid_outputs", {bus.div_ready, bus.div_dbz, bus.div_busy, bus.div_res},
          {3'b000, 64'd0});
    rst_n         = 1'b1;
    bus.div_start = 1'b0;
    run_op(1'b1, 32'hFFFF_FF00, 32'd7, 1'b1, "post_rst");

    // Random operands, with occasional zero, -1 and most-negative values.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a, b;
      bit sg;
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom) >> $urandom_range(0, 31);
        default: b = 32'($urandom);
      endcase
      run_op(sg, a, b, (i % 3) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
